// File: rtl/mshr_pkg.sv
// Shared types and helpers for the MSHR controller and its queue.
package mshr_pkg;

    localparam int MSHR_DEPTH = 4;
    localparam int MSHR_PTR_W = $clog2(MSHR_DEPTH);

    typedef enum logic {
        BUS_RD = 1'b0,
        BUS_WR = 1'b1
    } bus_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_ISSUE,
        STORE_WAIT
    } bus_state_e;

    typedef struct packed {
        logic [4:0]  regd;
        logic [31:0] addr;
        logic        issued;
        logic        done;
        logic [31:0] data;
    } mshr_entry_t;

    function automatic logic is_sp_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          aw
    );
        logic [31:0] diff;
        diff = addr ^ base;
        return (diff >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/mshr_queue.sv
// In-order circular MSHR buffer: allocate at tail, issue and fill in order,
// pop completed entries from head.
module mshr_queue
    import mshr_pkg::*;
#(
    parameter int NUM_MSHR = MSHR_DEPTH,
    localparam int PW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1,
    localparam int CW = $clog2(NUM_MSHR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  logic [4:0]    alloc_regd,
    input  logic [31:0]   alloc_addr,
    input  logic          issue,
    input  logic          rsp_valid,
    input  logic [31:0]   rsp_data,
    input  logic          pop,
    output mshr_entry_t   head,
    output logic          head_done,
    output logic          iss_avail,
    output logic [31:0]   iss_addr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    mshr_entry_t         ent [NUM_MSHR];
    logic [NUM_MSHR-1:0] vld;
    logic [PW-1:0]       head_p;
    logic [PW-1:0]       tail_p;
    logic [PW-1:0]       iss_p;
    logic [PW-1:0]       rsp_p;
    logic                do_alloc;
    logic                do_issue;
    logic                do_pop;
    logic                rsp_hit;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NUM_MSHR - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head      = ent[head_p];
    assign head_done = vld[head_p] && ent[head_p].done;
    assign iss_avail = vld[iss_p] && !ent[iss_p].issued;
    assign iss_addr  = ent[iss_p].addr;
    assign full      = (count == CW'(NUM_MSHR));
    assign empty     = (count == '0);

    assign do_alloc = alloc && !full;
    assign do_issue = issue && iss_avail;
    assign do_pop   = pop && head_done;
    // Responses come back in issue order, so the fill target is a pointer.
    assign rsp_hit  = rsp_valid && vld[rsp_p]
                   && ent[rsp_p].issued && !ent[rsp_p].done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                ent[i] <= '0;
            end
            vld    <= '0;
            head_p <= '0;
            tail_p <= '0;
            iss_p  <= '0;
            rsp_p  <= '0;
            count  <= '0;
        end else begin
            if (do_alloc) begin
                ent[tail_p].regd   <= alloc_regd;
                ent[tail_p].addr   <= alloc_addr;
                ent[tail_p].issued <= 1'b0;
                ent[tail_p].done   <= 1'b0;
                ent[tail_p].data   <= '0;
                vld[tail_p]        <= 1'b1;
                tail_p             <= nxt(tail_p);
            end
            if (do_issue) begin
                ent[iss_p].issued <= 1'b1;
                iss_p             <= nxt(iss_p);
            end
            if (rsp_hit) begin
                ent[rsp_p].data <= rsp_data;
                ent[rsp_p].done <= 1'b1;
                rsp_p           <= nxt(rsp_p);
            end
            if (do_pop) begin
                vld[head_p] <= 1'b0;
                head_p      <= nxt(head_p);
            end
            if (do_alloc && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_alloc) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mshr_ctrl.sv
// Mem-side controller: scratchpad hits, MSHR-tracked slow loads, posted stores.
// Define MSHR_PERF_EN to add miss/stall counters and an occupancy high-water mark.
module mshr_ctrl
    import mshr_pkg::*;
#(
    parameter int          NUM_MSHR = MSHR_DEPTH,
    parameter logic [31:0] SP_BASE  = 32'h0000_0000,
    parameter int          SP_AW    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mmio_req,
    input  logic            mmio_lw,
    input  logic [31:0]     mmio_addr,
    input  logic [31:0]     mmio_data_write,
    input  logic [4:0]      mmio_regD,
    output logic [31:0]     mmio_data_read,
    output logic            hit_ack,
    output logic            miss_store,
    output logic            load_done_stall,
    output logic            passive_stall,
    output logic [4:0]      regD_done,
    output logic [SP_AW-3:0] sp_addr,
    output logic            sp_we,
    output logic [31:0]     sp_wdata,
    input  logic [31:0]     sp_rdata,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_req_we,
    output logic [31:0]     bus_req_addr,
    output logic [31:0]     bus_req_wdata,
    input  logic [31:0]     bus_resp_data,
`ifdef MSHR_PERF_EN
    output logic [31:0]     perf_miss_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [2:0]      perf_max_occ,
`endif
    input  logic            bus_resp_valid
);

    localparam int CW = $clog2(NUM_MSHR + 1);

    mshr_entry_t   q_head;
    logic          q_head_done;
    logic          q_iss_avail;
    logic [31:0]   q_iss_addr;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          q_alloc;
    logic          q_issue;
    logic          q_pop;

    bus_state_e    state;
    bus_state_e    state_nxt;
    logic [31:0]   st_addr;
    logic [31:0]   st_wdata;
    logic          sp_hit;
    logic          store_req;
    logic          st_done;

    mshr_queue #(.NUM_MSHR(NUM_MSHR)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .alloc      (q_alloc),
        .alloc_regd (mmio_regD),
        .alloc_addr (mmio_addr),
        .issue      (q_issue),
        .rsp_valid  (bus_resp_valid),
        .rsp_data   (bus_resp_data),
        .pop        (q_pop),
        .head       (q_head),
        .head_done  (q_head_done),
        .iss_avail  (q_iss_avail),
        .iss_addr   (q_iss_addr),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign sp_hit = is_sp_addr(mmio_addr, SP_BASE, SP_AW);

    // Slow stores may only reach the bus once every older load has drained.
    assign store_req = rst && mmio_req && !mmio_lw && !sp_hit
                    && !q_head_done && q_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            st_addr  <= '0;
            st_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == STORE_WAIT) begin
                st_addr  <= mmio_addr;
                st_wdata <= mmio_data_write;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus_req_valid = 1'b0;
        bus_req_we    = 1'b0;
        bus_req_addr  = '0;
        bus_req_wdata = '0;
        q_issue       = 1'b0;
        unique case (state)
            IDLE: begin
                if (q_iss_avail) begin
                    bus_req_valid = 1'b1;
                    bus_req_we    = logic'(BUS_RD);
                    bus_req_addr  = q_iss_addr;
                    q_issue       = bus_req_ready;
                    if (!bus_req_ready) state_nxt = LOAD_ISSUE;
                end else if (store_req) begin
                    bus_req_valid = 1'b1;
                    bus_req_we    = logic'(BUS_WR);
                    bus_req_addr  = mmio_addr;
                    bus_req_wdata = mmio_data_write;
                    if (!bus_req_ready) state_nxt = STORE_WAIT;
                end
            end
            LOAD_ISSUE: begin
                bus_req_valid = 1'b1;
                bus_req_we    = logic'(BUS_RD);
                bus_req_addr  = q_iss_addr;
                q_issue       = bus_req_ready;
                if (bus_req_ready) state_nxt = IDLE;
            end
            STORE_WAIT: begin
                bus_req_valid = 1'b1;
                bus_req_we    = logic'(BUS_WR);
                bus_req_addr  = st_addr;
                bus_req_wdata = st_wdata;
                if (bus_req_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign st_done = bus_req_valid && bus_req_we && bus_req_ready;

    // Injection outranks the mem stage, which re-presents its request.
    always_comb begin
        mmio_data_read  = '0;
        hit_ack         = 1'b0;
        miss_store      = 1'b0;
        load_done_stall = 1'b0;
        passive_stall   = 1'b0;
        regD_done       = '0;
        sp_addr         = '0;
        sp_we           = 1'b0;
        sp_wdata        = '0;
        q_alloc         = 1'b0;
        q_pop           = 1'b0;
        if (rst) begin
            if (q_head_done) begin
                load_done_stall = 1'b1;
                regD_done       = q_head.regd;
                mmio_data_read  = q_head.data;
                q_pop           = 1'b1;
            end else if (mmio_req) begin
                if (sp_hit) begin
                    sp_addr = mmio_addr[SP_AW-1:2];
                    hit_ack = 1'b1;
                    if (mmio_lw) begin
                        mmio_data_read = sp_rdata;
                    end else begin
                        sp_we    = 1'b1;
                        sp_wdata = mmio_data_write;
                    end
                end else if (mmio_lw) begin
                    miss_store    = !q_full;
                    q_alloc       = !q_full;
                    passive_stall = q_full;
                end else begin
                    passive_stall = !st_done;
                end
            end
        end
    end

`ifdef MSHR_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_miss_cnt  <= '0;
            perf_stall_cnt <= '0;
            perf_max_occ   <= '0;
        end else begin
            if (miss_store) perf_miss_cnt <= perf_miss_cnt + 32'd1;
            if (passive_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (3'(q_count) > perf_max_occ) perf_max_occ <= 3'(q_count);
        end
    end
`endif

endmodule

// File: tb/tb_mshr_ctrl.sv
// Directed self-checking bench for mshr_ctrl.
module tb_mshr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_req;
    logic        mmio_lw;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_data_write;
    logic [4:0]  mmio_regD;
    logic [31:0] mmio_data_read;
    logic        hit_ack;
    logic        miss_store;
    logic        load_done_stall;
    logic        passive_stall;
    logic [4:0]  regD_done;
    logic [9:0]  sp_addr;
    logic        sp_we;
    logic [31:0] sp_wdata;
    logic [31:0] sp_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [31:0] bus_resp_data;
    logic        bus_resp_valid;

    int checks = 0;
    int failures = 0;

    wire [3:0] ctl = {hit_ack, miss_store, load_done_stall, passive_stall};

    always #5 clk = ~clk;

    mshr_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mmio_req        (mmio_req),
        .mmio_lw         (mmio_lw),
        .mmio_addr       (mmio_addr),
        .mmio_data_write (mmio_data_write),
        .mmio_regD       (mmio_regD),
        .mmio_data_read  (mmio_data_read),
        .hit_ack         (hit_ack),
        .miss_store      (miss_store),
        .load_done_stall (load_done_stall),
        .passive_stall   (passive_stall),
        .regD_done       (regD_done),
        .sp_addr         (sp_addr),
        .sp_we           (sp_we),
        .sp_wdata        (sp_wdata),
        .sp_rdata        (sp_rdata),
        .bus_req_valid   (bus_req_valid),
        .bus_req_ready   (bus_req_ready),
        .bus_req_we      (bus_req_we),
        .bus_req_addr    (bus_req_addr),
        .bus_req_wdata   (bus_req_wdata),
        .bus_resp_data   (bus_resp_data),
        .bus_resp_valid  (bus_resp_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic req, input logic lw,
                       input logic [31:0] a, input logic [4:0] rd);
        mmio_req  = req;
        mmio_lw   = lw;
        mmio_addr = a;
        mmio_regD = rd;
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        bus_resp_valid = v;
        bus_resp_data  = d;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 5'd0);
        mmio_data_write = '0;
        sp_rdata = '0;
        bus_req_ready = 1'b0;
        resp(1'b0, '0);
        repeat (3) tick;
        #2;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL rst_ctl got=%b exp=0000", ctl); end
        checks++; if ({bus_req_valid, sp_we, mmio_data_read} !== 34'h0) begin failures++; $display("FAIL rst_out got=%h exp=0", {bus_req_valid, sp_we, mmio_data_read}); end
        tick;
        rst = 1'b1;
        tick; #2;
        checks++; if ({ctl, bus_req_valid, regD_done} !== 10'h0) begin failures++; $display("FAIL idle_out got=%h exp=0", {ctl, bus_req_valid, regD_done}); end
    endtask

    task automatic test_sp;
        tick;
        drv(1'b1, 1'b1, 32'h0000_0010, 5'd1);
        sp_rdata = 32'h1234_5678;
        #2;
        checks++; if (ctl !== 4'b1000) begin failures++; $display("FAIL sp_ld_ctl got=%b exp=1000", ctl); end
        checks++; if (mmio_data_read !== 32'h1234_5678) begin failures++; $display("FAIL sp_ld_data got=%h exp=12345678", mmio_data_read); end
        checks++; if (sp_addr !== 10'd4) begin failures++; $display("FAIL sp_ld_addr got=%h exp=4", sp_addr); end
        tick;
        drv(1'b1, 1'b0, 32'h0000_0FFC, 5'd0);
        mmio_data_write = 32'hDEAD_BEEF;
        #2;
        checks++; if ({ctl, sp_we} !== 5'b10001) begin failures++; $display("FAIL sp_st_ctl got=%b exp=10001", {ctl, sp_we}); end
        checks++; if ({sp_addr, sp_wdata} !== {10'h3FF, 32'hDEAD_BEEF}) begin failures++; $display("FAIL sp_st_bus got=%h exp=3ffdeadbeef", {sp_addr, sp_wdata}); end
        checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL sp_st_nobus got=%b exp=0", bus_req_valid); end
    endtask

    task automatic test_slow_loads;
        bus_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            drv(1'b1, 1'b1, 32'h8000_0000 + 32'(4 * i), 5'(5 + i));
            #2;
            checks++; if (ctl !== 4'b0100) begin failures++; $display("FAIL alloc%0d_ctl got=%b exp=0100", i, ctl); end
            if (i > 0) begin
                checks++; if ({bus_req_valid, bus_req_we, bus_req_addr} !== {2'b10, 32'h8000_0000 + 32'(4 * (i - 1))}) begin failures++; $display("FAIL issue%0d got=%h", i, {bus_req_valid, bus_req_we, bus_req_addr}); end
            end
        end
        tick;
        drv(1'b1, 1'b1, 32'h8000_0010, 5'd9);
        #2;
        checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL full_ctl got=%b exp=0001", ctl); end
        checks++; if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h8000_000C}) begin failures++; $display("FAIL issue3 got=%h", {bus_req_valid, bus_req_addr}); end
        tick;
        resp(1'b1, 32'hAAAA_0001);
        #2;
        checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL full_hold got=%b exp=0001", ctl); end
        checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL all_issued got=%b exp=0", bus_req_valid); end
        tick;
        resp(1'b0, '0);
        #2;
        checks++; if ({ctl, regD_done, mmio_data_read} !== {4'b0010, 5'd5, 32'hAAAA_0001}) begin failures++; $display("FAIL fill_a got=%h", {ctl, regD_done, mmio_data_read}); end
        tick; #2;
        checks++; if (ctl !== 4'b0100) begin failures++; $display("FAIL alloc_after_fill got=%b exp=0100", ctl); end
        tick;
        drv(1'b0, 1'b0, 32'h0, 5'd0);
        #2;
        checks++; if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h8000_0010}) begin failures++; $display("FAIL wrap_issue got=%h", {bus_req_valid, bus_req_addr}); end
    endtask

    task automatic test_fills;
        logic [31:0] dat [4];
        dat[0] = 32'hBBBB_0002;
        dat[1] = 32'hCCCC_0003;
        dat[2] = 32'hDDDD_0004;
        dat[3] = 32'hEEEE_0005;
        tick;
        resp(1'b1, dat[0]);
        #2;
        checks++; if (load_done_stall !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", load_done_stall); end
        sp_rdata = 32'hCAFE_0000;
        for (int i = 0; i < 4; i++) begin
            tick;
            drv(1'b1, 1'b1, 32'h0000_0020, 5'd2);
            if (i < 3) resp(1'b1, dat[i + 1]);
            else resp(1'b0, '0);
            #2;
            checks++; if ({ctl, sp_we, regD_done, mmio_data_read} !== {5'b00100, 5'(6 + i), dat[i]}) begin failures++; $display("FAIL fill%0d got=%h exp=%h", i, {ctl, sp_we, regD_done, mmio_data_read}, {5'b00100, 5'(6 + i), dat[i]}); end
        end
        tick; #2;
        checks++; if ({ctl, mmio_data_read} !== {4'b1000, 32'hCAFE_0000}) begin failures++; $display("FAIL post_fill_hit got=%h", {ctl, mmio_data_read}); end
        tick;
        drv(1'b0, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic test_store_wait;
        tick;
        drv(1'b1, 1'b1, 32'h9000_0000, 5'd10);
        tick;
        drv(1'b1, 1'b1, 32'h9000_0004, 5'd11);
        #2;
        checks++; if (ctl !== 4'b0100) begin failures++; $display("FAIL st_alloc got=%b exp=0100", ctl); end
        tick;
        drv(1'b1, 1'b0, 32'hA000_0000, 5'd0);
        mmio_data_write = 32'h5555_AAAA;
        #2;
        checks++; if ({ctl, bus_req_we, bus_req_addr} !== {4'b0001, 1'b0, 32'h9000_0004}) begin failures++; $display("FAIL st_stall0 got=%h", {ctl, bus_req_we, bus_req_addr}); end
        tick;
        bus_req_ready = 1'b0;
        resp(1'b1, 32'h1111_0000);
        #2;
        checks++; if ({ctl, bus_req_valid} !== 5'b00010) begin failures++; $display("FAIL st_stall1 got=%b exp=00010", {ctl, bus_req_valid}); end
        tick;
        resp(1'b1, 32'h2222_0000);
        #2;
        checks++; if ({ctl, regD_done, mmio_data_read} !== {4'b0010, 5'd10, 32'h1111_0000}) begin failures++; $display("FAIL st_fill0 got=%h", {ctl, regD_done, mmio_data_read}); end
        tick;
        resp(1'b0, '0);
        #2;
        checks++; if ({ctl, regD_done, bus_req_valid} !== {4'b0010, 5'd11, 1'b0}) begin failures++; $display("FAIL st_fill1 got=%h", {ctl, regD_done, bus_req_valid}); end
        tick; #2;
        checks++; if ({ctl, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata} !== {4'b0001, 2'b11, 32'hA000_0000, 32'h5555_AAAA}) begin failures++; $display("FAIL st_on_bus got=%h", {ctl, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata}); end
        tick;
        bus_req_ready = 1'b1;
        #2;
        checks++; if ({ctl, bus_req_valid, bus_req_we, bus_req_addr} !== {4'b0000, 2'b11, 32'hA000_0000}) begin failures++; $display("FAIL st_done got=%h", {ctl, bus_req_valid, bus_req_we, bus_req_addr}); end
        tick;
        drv(1'b0, 1'b0, 32'h0, 5'd0);
        bus_req_ready = 1'b0;
        #2;
        checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL st_retire got=%b exp=0", bus_req_valid); end
    endtask

    task automatic test_ready_hold;
        tick;
        drv(1'b1, 1'b1, 32'hB000_0000, 5'd12);
        tick;
        drv(1'b1, 1'b1, 32'hB000_0004, 5'd13);
        mmio_data_write = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata} !== {2'b10, 32'hB000_0000, 32'h0}) begin failures++; $display("FAIL hold%0d got=%h", i, {bus_req_valid, bus_req_we, bus_req_addr}); end
            tick;
            drv(1'b0, 1'b0, 32'h0, 5'd0);
        end
        bus_req_ready = 1'b1;
        #2;
        checks++; if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'hB000_0000}) begin failures++; $display("FAIL hold_hs got=%h", {bus_req_valid, bus_req_addr}); end
        tick; #2;
        checks++; if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'hB000_0004}) begin failures++; $display("FAIL hold_next got=%h", {bus_req_valid, bus_req_addr}); end
        tick;
        bus_req_ready = 1'b0;
        resp(1'b1, 32'h0000_0012);
        #2;
        checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL hold_drain got=%b exp=0", bus_req_valid); end
        tick;
        resp(1'b1, 32'h0000_0013);
        #2;
        checks++; if ({load_done_stall, regD_done, mmio_data_read} !== {1'b1, 5'd12, 32'h12}) begin failures++; $display("FAIL hold_fill0 got=%h", {load_done_stall, regD_done, mmio_data_read}); end
        tick;
        resp(1'b0, '0);
        #2;
        checks++; if ({load_done_stall, regD_done, mmio_data_read} !== {1'b1, 5'd13, 32'h13}) begin failures++; $display("FAIL hold_fill1 got=%h", {load_done_stall, regD_done, mmio_data_read}); end
        tick; #2;
        checks++; if (load_done_stall !== 1'b0) begin failures++; $display("FAIL hold_empty got=%b exp=0", load_done_stall); end
    endtask

    task automatic test_reset_mid;
        bus_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            drv(1'b1, 1'b1, 32'hC000_0000 + 32'(4 * i), 5'(14 + i));
        end
        tick;
        drv(1'b1, 1'b1, 32'hC000_0010, 5'd17);
        bus_req_ready = 1'b0;
        #3;
        rst = 1'b0;
        resp(1'b1, 32'hFFFF_0000);
        #1;
        checks++; if ({ctl, bus_req_valid, bus_req_we, sp_we} !== 7'h0) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=0", {ctl, bus_req_valid, bus_req_we, sp_we}); end
        checks++; if ({mmio_data_read, regD_done, sp_addr, bus_req_addr} !== 79'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", {mmio_data_read, regD_done, sp_addr, bus_req_addr}); end
        tick;
        rst = 1'b1;
        resp(1'b0, '0);
        drv(1'b1, 1'b1, 32'h0000_0040, 5'd3);
        sp_rdata = 32'h0BAD_F00D;
        #2;
        checks++; if ({ctl, mmio_data_read} !== {4'b1000, 32'h0BAD_F00D}) begin failures++; $display("FAIL rst_sp_hit got=%h", {ctl, mmio_data_read}); end
        tick;
        drv(1'b0, 1'b0, 32'h0, 5'd0);
        resp(1'b1, 32'h0000_DEAD);
        #2;
        checks++; if ({load_done_stall, bus_req_valid} !== 2'b00) begin failures++; $display("FAIL rst_stale0 got=%b exp=00", {load_done_stall, bus_req_valid}); end
        tick;
        resp(1'b0, '0);
        #2;
        checks++; if ({ctl, bus_req_valid} !== 5'b0) begin failures++; $display("FAIL rst_stale1 got=%b exp=0", {ctl, bus_req_valid}); end
    endtask

    initial begin
        test_reset;
        test_sp;
        test_slow_loads;
        test_fills;
        test_store_wait;
        test_ready_hold;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mshr_ctrl.md
Name: mshr_ctrl

Overview:
Memory-side controller behind the mem stage. It drives the hit_ack, miss_store, load_done_stall, passive_stall and regD_done handshake, and serves scratchpad accesses in the same cycle. Slow-region loads are tracked in an in-order MSHR queue and issued to the slow bus. Completed fills are injected back into the pipeline one per cycle.

Parameters:
NUM_MSHR, 4, outstanding slow loads; must equal the mem stage's MSHR_REG.
SP_BASE, 32'h0000_0000, scratchpad base address, aligned to its size.
SP_AW, 12, log2 of scratchpad size in bytes; word-addressed internally.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mmio_req  in  1  access request from mem stage
mmio_lw  in  1  1 = load, 0 = store
mmio_addr  in  32  byte address, word-aligned
mmio_data_write  in  32  store data
mmio_regD  in  5  load destination register
mmio_data_read  out  32  hit data, or fill data while load_done_stall
hit_ack  out  1  scratchpad access completed this cycle
miss_store  out  1  slow load allocated into MSHR
load_done_stall  out  1  fill injected this cycle
passive_stall  out  1  request cannot be accepted this cycle
regD_done  out  5  destination register of injected fill
sp_addr  out  SP_AW-2  scratchpad word index
sp_we  out  1  scratchpad write enable
sp_wdata  out  32  scratchpad write data
sp_rdata  in  32  combinational scratchpad read data
bus_req_valid  out  1  slow-bus request valid
bus_req_ready  in  1  slow-bus request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  32  slow-bus address
bus_req_wdata  out  32  slow-bus write data
bus_resp_valid  in  1  read response valid; responses arrive in issue order; no backpressure

Behaviour:
- Reset (rst low, asynchronous): queue empty, head = tail = issue pointer = count = 0, all entries invalid. All outputs are 0 except mmio_data_read = 0.
- Scratchpad hit: mmio_addr[31:SP_AW] == SP_BASE[31:SP_AW].
- At most one of hit_ack, miss_store, load_done_stall, passive_stall is high in any cycle.
- Each entry holds {regD, addr, issued, done, data}. The queue is circular; pointers wrap modulo NUM_MSHR.
- Priority 1, fill injection: the head entry is done → load_done_stall=1, regD_done=head.regD, mmio_data_read=head.data, pop head. mmio_req is ignored this cycle (the mem stage re-presents it).
- Priority 2, scratchpad request: sp_addr = mmio_addr[SP_AW-1:2].
  - Load: mmio_data_read=sp_rdata, hit_ack=1. Zero-cycle latency.
  - Store: sp_we=1, hit_ack=1.
- Priority 3, slow load: count<NUM_MSHR → miss_store=1, write entry at tail {regD, addr, issued=0, done=0}, tail++. Queue full → passive_stall=1.
- Priority 4, slow store: passive_stall=1 until count==0 and the bus accepts the write.
  - The store drives the bus only while count==0; bus_req_we=1.
  - The cycle bus_req_ready=1 with the store on the bus: passive_stall=0 and the store is complete (posted).
- Bus issue:
  - When the queue is non-empty, the bus is driven by the oldest unissued entry; bus_req_we=0.
  - An entry is marked issued on valid&&ready.
  - bus_req_valid is never retracted before ready.
- Response: bus_resp_valid writes data into the oldest issued-not-done entry and sets done. The response and injection (pop) of a different entry may occur in the same cycle.
- A response for an entry is visible as a fill no earlier than the next cycle; it never bypasses combinationally.
- Simultaneous allocate and pop: not possible (allocation loses to priority 1), so count changes by at most 1 per cycle.
- mmio_req=0: no hit_ack, miss_store or passive_stall. Fill injection still proceeds.
- Reset mid-operation: all entries are dropped, with no bus handshake completion required.

Optional Feature:
MSHR_PERF_EN: adds outputs perf_miss_cnt[31:0] (increments on miss_store), perf_stall_cnt[31:0] (increments on passive_stall) and perf_max_occ[2:0] (high-water mark of count). All reset to 0, wrap on overflow. Without the macro the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- mshr_pkg: mshr_entry_t struct, pointer width constant $clog2(NUM_MSHR), bus command encoding, helper function is_sp_addr().
- Sub-module mshr_queue: circular buffer with alloc, issue-mark, response-fill and pop ports, plus full/empty/count.
- mshr_ctrl keeps the priority logic and the bus FSM (IDLE, LOAD_ISSUE, STORE_WAIT).

Test Plan:
1. Scratchpad load: sp_rdata=32'h1234_5678 → hit_ack=1, mmio_data_read=32'h1234_5678 in the same cycle; miss_store and passive_stall stay 0.
2. Four slow loads to regs 5,6,7,8 with bus_req_ready=1 → miss_store on each; fifth load gets passive_stall until the first fill.
3. Responses A,B,C,D → load_done_stall pulses with regD_done 5,6,7,8 and data A..D in order, one per cycle minimum, with no other control signal high on those cycles.
4. Slow store while 2 loads are outstanding → passive_stall holds until both fills are injected, then bus_req_we=1; completion on the ready cycle.
5. bus_req_ready held low 3 cycles → bus_req_valid, addr and data stable throughout; entry marked issued only on the handshake.
6. rst asserted with 3 entries outstanding → all outputs 0 immediately; after release a scratchpad load gets hit_ack and no stale fill appears.
